// File: rtl/memtest_pkg.sv
// Shared types and helpers for the Avalon-MM memory self-test:
// FSM state encoding, LFSR polynomial, pattern word builder and seed fixup.
package memtest_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CAL,
    WR,
    RD_CMD,
    RD_DATA,
    DONE
  } state_t;

  // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // One Galois LFSR step
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_POLY) : (l >> 1);
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  function automatic logic [31:0] seed_fixup(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  // 128-bit beat word built from four 32-bit lanes; addr is the beat address
  function automatic logic [127:0] pattern_word(input logic [31:0] l, input logic [31:0] addr);
    return {l, ~l, l ^ addr, l[15:0], l[31:16]};
  endfunction

endpackage

// File: rtl/memtest_lfsr.sv
// 32-bit Galois LFSR with synchronous load (seed fixed up) and step enable.
module memtest_lfsr (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);
  import memtest_pkg::*;

  // Load has priority over step so a new run always starts from its seed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  state <= 32'h1;
    else if (load) state <= seed_fixup(seed);
    else if (step) state <= lfsr_next(state);
  end

endmodule

// File: rtl/avl_mem_bist.sv
// Avalon-MM memory self-test: writes num_bursts bursts of an LFSR pattern,
// reads them back and compares every beat, reporting pass/fail, error count
// and first failing beat address.
// Optional build macro AVL_MEM_BIST_ERR_INJECT_EN adds input inject_err, which
// flips bit 0 of the next written beat so exactly one read error is produced.
module avl_mem_bist #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic                calib_done,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [15:0]         num_bursts,
  input  logic [31:0]         seed,
`ifdef AVL_MEM_BIST_ERR_INJECT_EN
  input  logic                inject_err,
`endif
  input  logic                avl_ready,
  output logic                avl_burstbegin,
  output logic [ADDR_W-1:0]   avl_address,
  output logic [7:0]          avl_size,
  output logic                avl_write_req,
  output logic [DATA_W-1:0]   avl_wdata,
  output logic [DATA_W/8-1:0] avl_be,
  output logic                avl_read_req,
  input  logic                avl_rdata_valid,
  input  logic [DATA_W-1:0]   avl_rdata,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [31:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);
  import memtest_pkg::*;

  localparam logic [7:0]        BL8     = 8'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BL_ADDR = ADDR_W'(BURST_LEN);

  state_t              state, next_state;
  logic [ADDR_W-1:0]   base_q;
  logic [15:0]         num_q;
  logic [ADDR_W-1:0]   burst_addr;
  logic [15:0]         burst_idx;
  logic [7:0]          beat_idx;
  logic [7:0]          rd_left;
  logic                err_seen;
  logic [31:0]         wr_l, rd_l;
  logic                start_ok, wr_acc, rd_acc, rd_beat, rd_last;
  logic                wr_last_beat, last_burst, mismatch;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [127:0]        wr_word, exp_word;

  assign start_ok     = start && !abort && (state == IDLE || state == DONE);
  assign wr_acc       = (state == WR) && avl_ready;
  assign rd_acc       = (state == RD_CMD) && (rd_left == 8'd0) && avl_ready;
  assign rd_beat      = (state == RD_DATA) && avl_rdata_valid && (rd_left != 8'd0);
  assign rd_last      = rd_beat && (rd_left == 8'd1);
  assign wr_last_beat = (beat_idx == BL8 - 8'd1);
  assign last_burst   = (burst_idx == num_q - 16'd1);
  assign wr_addr      = burst_addr + ADDR_W'(beat_idx);
  assign rd_addr      = burst_addr + ADDR_W'(BL8 - rd_left);
  assign exp_word     = pattern_word(rd_l, 32'(rd_addr));
  assign mismatch     = rd_beat && (avl_rdata != DATA_W'(exp_word));

`ifdef AVL_MEM_BIST_ERR_INJECT_EN
  logic inj_flag;

  // Arm on inject pulse, disarm once the corrupted beat has been accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 inj_flag <= 1'b0;
    else if (wr_acc && inj_flag)  inj_flag <= 1'b0;
    else if (inject_err)          inj_flag <= 1'b1;
  end

  assign wr_word = pattern_word(wr_l, 32'(wr_addr)) ^ {127'b0, inj_flag};
`else
  assign wr_word = pattern_word(wr_l, 32'(wr_addr));
`endif

  // Write generator and read checker run identical sequences from the same seed
  memtest_lfsr u_wr_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start_ok),
    .seed    (seed),
    .step    (wr_acc),
    .state   (wr_l)
  );

  memtest_lfsr u_rd_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start_ok),
    .seed    (seed),
    .step    (rd_beat),
    .state   (rd_l)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) next_state = (num_bursts == 16'd0) ? DONE : WAIT_CAL;
        WAIT_CAL:   if (calib_done) next_state = WR;
        WR:         if (wr_acc && wr_last_beat && last_burst) next_state = RD_CMD;
        RD_CMD:     if (rd_acc) next_state = RD_DATA;
        RD_DATA:    if (rd_last) next_state = last_burst ? DONE : RD_CMD;
        default:    next_state = IDLE;
      endcase
    end
  end

  // Avalon request outputs decoded from state; read waits for any drain to finish
  always_comb begin
    avl_write_req  = (state == WR);
    avl_read_req   = (state == RD_CMD) && (rd_left == 8'd0);
    avl_burstbegin = ((state == WR) && (beat_idx == 8'd0)) || avl_read_req;
    avl_address    = '0;
    avl_wdata      = '0;
    if (state == WR) begin
      avl_address = wr_addr;
      avl_wdata   = DATA_W'(wr_word);
    end else if (state == RD_CMD) begin
      avl_address = burst_addr;
    end
    busy = (state != IDLE) && (state != DONE);
  end

  assign avl_size = BL8;
  assign avl_be   = '1;

  // Burst/beat bookkeeping, error accounting and result flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q         <= '0;
      num_q          <= '0;
      burst_addr     <= '0;
      burst_idx      <= '0;
      beat_idx       <= '0;
      err_seen       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else if (start_ok) begin
      base_q         <= base_addr;
      num_q          <= num_bursts;
      burst_addr     <= base_addr;
      burst_idx      <= '0;
      beat_idx       <= '0;
      err_seen       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      done           <= (num_bursts == 16'd0);
      pass           <= (num_bursts == 16'd0);
    end else begin
      if (wr_acc) begin
        if (wr_last_beat) begin
          beat_idx <= '0;
          if (last_burst) begin
            burst_idx  <= '0;
            burst_addr <= base_q;
          end else begin
            burst_idx  <= burst_idx + 16'd1;
            burst_addr <= burst_addr + BL_ADDR;
          end
        end else begin
          beat_idx <= beat_idx + 8'd1;
        end
      end
      if (rd_last) begin
        burst_idx  <= burst_idx + 16'd1;
        burst_addr <= burst_addr + BL_ADDR;
      end
      if (mismatch) begin
        err_seen <= 1'b1;
        if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
        if (!err_seen) first_err_addr <= rd_addr;
      end
      if (next_state == DONE && state != DONE) begin
        done <= 1'b1;
        pass <= !(err_seen || mismatch);
      end
    end
  end

  // Beats still owed by the memory; survives abort so stale data is drained
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   rd_left <= '0;
    else if (rd_acc)                                rd_left <= BL8;
    else if (avl_rdata_valid && rd_left != 8'd0)    rd_left <= rd_left - 8'd1;
  end

endmodule

// File: tb/tb_avl_mem_bist.sv
// Directed self-checking bench for avl_mem_bist with a behavioural Avalon memory.
module tb_avl_mem_bist;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 128;
  localparam int BL     = 8;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                calib_done = 1'b1;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [15:0]         num_bursts = '0;
  logic [31:0]         seed = '0;
`ifdef AVL_MEM_BIST_ERR_INJECT_EN
  logic                inject_err = 1'b0;
`endif
  logic                avl_ready = 1'b0;
  logic                avl_burstbegin;
  logic [ADDR_W-1:0]   avl_address;
  logic [7:0]          avl_size;
  logic                avl_write_req;
  logic [DATA_W-1:0]   avl_wdata;
  logic [DATA_W/8-1:0] avl_be;
  logic                avl_read_req;
  logic                avl_rdata_valid = 1'b0;
  logic [DATA_W-1:0]   avl_rdata = '0;
  logic                busy, done, pass;
  logic [31:0]         err_count;
  logic [ADDR_W-1:0]   first_err_addr;

  int checks = 0;
  int errors = 0;

  avl_mem_bist dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .calib_done      (calib_done),
    .base_addr       (base_addr),
    .num_bursts      (num_bursts),
    .seed            (seed),
`ifdef AVL_MEM_BIST_ERR_INJECT_EN
    .inject_err      (inject_err),
`endif
    .avl_ready       (avl_ready),
    .avl_burstbegin  (avl_burstbegin),
    .avl_address     (avl_address),
    .avl_size        (avl_size),
    .avl_write_req   (avl_write_req),
    .avl_wdata       (avl_wdata),
    .avl_be          (avl_be),
    .avl_read_req    (avl_read_req),
    .avl_rdata_valid (avl_rdata_valid),
    .avl_rdata       (avl_rdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_addr  (first_err_addr)
  );

  always #5 clk = ~clk;

  // Memory model configuration, written by the stimulus process only
  bit                model_clr = 1'b0;
  bit                stall_mode = 1'b0;
  bit                corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  logic [31:0]       model_seed = '0;

  // Memory model state, written by the model process only
  logic [127:0]      mem [int];
  logic [127:0]      rsp_q [$];
  logic [ADDR_W-1:0] wr_cmd_addr [$];
  logic [ADDR_W-1:0] rd_cmd_addr [$];
  int                wr_beats, rd_cmds, wd_bad, bb_bad, stable_bad, stall_seen;
  int                cyc, last_valid_cyc, done_cyc;
  int                wr_beat;
  logic [ADDR_W-1:0] wr_base;
  logic [31:0]       exp_l;
  logic [127:0]      wdata0, wdata1;
  logic              prev_stall, prev_bb, done_q;
  logic [127:0]      prev_wdata;
  logic [ADDR_W-1:0] prev_addr;

  function automatic logic [31:0] m_step(input logic [31:0] l);
    logic [31:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic logic [127:0] m_word(input logic [31:0] l, input logic [ADDR_W-1:0] a);
    logic [31:0] a32;
    a32 = {7'b0, a};
    return {l, ~l, l ^ a32, l[15:0], l[31:16]};
  endfunction

  // Avalon memory model: decides ready, records accepted beats, returns read bursts
  always @(negedge clk) begin : model
    logic [ADDR_W-1:0] a;
    logic [127:0]      d;
    if (model_clr) begin
      wr_beats = 0; rd_cmds = 0; wd_bad = 0; bb_bad = 0; stable_bad = 0; stall_seen = 0;
      last_valid_cyc = 0; done_cyc = -100; wr_beat = 0; wr_base = '0;
      exp_l = (model_seed == 32'h0) ? 32'h1 : model_seed;
      wdata0 = '0; wdata1 = '0; prev_stall = 1'b0;
      rsp_q.delete(); wr_cmd_addr.delete(); rd_cmd_addr.delete();
    end
    if (done && !done_q) done_cyc = cyc;
    done_q = done;
    if (prev_stall) begin
      stall_seen++;
      if (avl_wdata !== prev_wdata || avl_address !== prev_addr || avl_burstbegin !== prev_bb)
        stable_bad++;
    end
    if (rsp_q.size() > 0 && !(stall_mode && $urandom_range(99) < 30)) begin
      avl_rdata_valid = 1'b1;
      avl_rdata       = rsp_q.pop_front();
      last_valid_cyc  = cyc;
    end else begin
      avl_rdata_valid = 1'b0;
    end
    avl_ready  = stall_mode ? ($urandom_range(99) >= 30) : 1'b1;
    prev_stall = avl_write_req && !avl_ready;
    prev_wdata = avl_wdata;
    prev_addr  = avl_address;
    prev_bb    = avl_burstbegin;
    if (avl_write_req && avl_ready) begin
      if (avl_burstbegin) begin
        if (wr_beat != 0) bb_bad++;
        wr_base = avl_address;
        wr_cmd_addr.push_back(avl_address);
      end else if (wr_beat == 0) begin
        bb_bad++;
      end
      a = wr_base + ADDR_W'(wr_beat);
      if (avl_wdata !== m_word(exp_l, a)) wd_bad++;
      if (wr_beats == 0) wdata0 = avl_wdata;
      if (wr_beats == 1) wdata1 = avl_wdata;
      mem[int'(a)] = avl_wdata;
      exp_l = m_step(exp_l);
      wr_beats++;
      wr_beat = (wr_beat + 1) % BL;
    end
    if (avl_read_req) begin
      if (!avl_burstbegin) bb_bad++;
      if (avl_ready) begin
        rd_cmds++;
        rd_cmd_addr.push_back(avl_address);
        for (int i = 0; i < BL; i++) begin
          a = avl_address + ADDR_W'(i);
          d = mem.exists(int'(a)) ? mem[int'(a)] : '0;
          if (corrupt_en && a == corrupt_addr) d[5] = ~d[5];
          rsp_q.push_back(d);
        end
      end
    end
    cyc++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clear the model, program run parameters and pulse start
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [15:0] num,
                               input logic [31:0] sd, input bit stall, input bit corrupt,
                               input logic [ADDR_W-1:0] caddr);
    stall_mode   = stall;
    corrupt_en   = corrupt;
    corrupt_addr = caddr;
    model_seed   = sd;
    model_clr    = 1'b1;
    @(negedge clk);
    #1 model_clr = 1'b0;
    @(posedge clk);
    #1;
    base_addr  = base;
    num_bursts = num;
    seed       = sd;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int reqs;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",  64'(busy), 64'd0);
    checkOutput("rst_done",  64'(done), 64'd0);
    checkOutput("rst_pass",  64'(pass), 64'd0);
    checkOutput("rst_err",   64'(err_count), 64'd0);
    checkOutput("rst_wreq",  64'(avl_write_req), 64'd0);
    checkOutput("rst_rreq",  64'(avl_read_req), 64'd0);
    checkOutput("rst_size",  64'(avl_size), 64'd8);
    checkOutput("rst_be",    64'(avl_be), 64'hFFFF);
    #1 reset_n = 1'b1;

    // Ideal memory, four bursts from address 0
    applyStimulus(25'h0, 16'd4, 32'h0000_ACE1, 1'b0, 1'b0, '0);
    waitDone("t1");
    checkOutput("t1_done",    64'(done), 64'd1);
    checkOutput("t1_pass",    64'(pass), 64'd1);
    checkOutput("t1_err",     64'(err_count), 64'd0);
    checkOutput("t1_busy",    64'(busy), 64'd0);
    checkOutput("t1_wbeats",  64'(wr_beats), 64'd32);
    checkOutput("t1_rdcmds",  64'(rd_cmds), 64'd4);
    checkOutput("t1_wdbad",   64'(wd_bad), 64'd0);
    checkOutput("t1_bbbad",   64'(bb_bad), 64'd0);
    checkOutput("t1_w0_hi",   wdata0[127:64], 64'h0000ACE1_FFFF531E);
    checkOutput("t1_w0_lo",   wdata0[63:0],   64'h0000ACE1_ACE10000);
    checkOutput("t1_w1_hi",   wdata1[127:64], 64'h80205673_7FDFA98C);
    checkOutput("t1_w1_lo",   wdata1[63:0],   64'h80205672_56738020);
    checkOutput("t1_done_lat", 64'(done_cyc - last_valid_cyc), 64'd1);
    if (rd_cmd_addr.size() == 4) checkOutput("t1_rdaddr3", 64'(rd_cmd_addr[3]), 64'h18);
    else checkOutput("t1_rdaddr_n", 64'(rd_cmd_addr.size()), 64'd4);

    // Random ready stalls and gapped read data
    applyStimulus(25'h0, 16'd4, 32'h0000_ACE1, 1'b1, 1'b0, '0);
    waitDone("t2");
    checkOutput("t2_pass",    64'(pass), 64'd1);
    checkOutput("t2_err",     64'(err_count), 64'd0);
    checkOutput("t2_wbeats",  64'(wr_beats), 64'd32);
    checkOutput("t2_rdcmds",  64'(rd_cmds), 64'd4);
    checkOutput("t2_wdbad",   64'(wd_bad), 64'd0);
    checkOutput("t2_stable",  64'(stable_bad), 64'd0);
    checkOutput("t2_stalled", 64'(stall_seen > 0), 64'd1);
    checkOutput("t2_done_lat", 64'(done_cyc - last_valid_cyc), 64'd1);

    // One corrupted beat: burst 2, beat 3 from base 0x100
    applyStimulus(25'h100, 16'd4, 32'h1234_5678, 1'b0, 1'b1, 25'h113);
    waitDone("t3");
    checkOutput("t3_done",  64'(done), 64'd1);
    checkOutput("t3_pass",  64'(pass), 64'd0);
    checkOutput("t3_err",   64'(err_count), 64'd1);
    checkOutput("t3_first", 64'(first_err_addr), 64'h113);

    // Address wrap at the top of the space, zero seed
    applyStimulus(25'h1FF_FFFC, 16'd2, 32'h0, 1'b0, 1'b0, '0);
    waitDone("t4");
    checkOutput("t4_pass",  64'(pass), 64'd1);
    checkOutput("t4_wdbad", 64'(wd_bad), 64'd0);
    if (wr_cmd_addr.size() == 2 && rd_cmd_addr.size() == 2) begin
      checkOutput("t4_wa0", 64'(wr_cmd_addr[0]), 64'h1FF_FFFC);
      checkOutput("t4_wa1", 64'(wr_cmd_addr[1]), 64'h000_0004);
      checkOutput("t4_ra1", 64'(rd_cmd_addr[1]), 64'h000_0004);
    end else begin
      checkOutput("t4_cmd_n", 64'(wr_cmd_addr.size() + rd_cmd_addr.size()), 64'd4);
    end

    // Calibration hold-off, then abort during the write phase
    calib_done = 1'b0;
    applyStimulus(25'h40, 16'd4, 32'h5, 1'b0, 1'b0, '0);
    reqs = 0;
    repeat (50) begin
      @(negedge clk);
      if (avl_write_req || avl_read_req) reqs++;
    end
    checkOutput("t5_noreq", 64'(reqs), 64'd0);
    checkOutput("t5_busy",  64'(busy), 64'd1);
    calib_done = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_beats >= 3) break;
    end
    checkOutput("t5_wr_started", 64'(wr_beats >= 3), 64'd1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checkOutput("t5_ab_wreq", 64'(avl_write_req), 64'd0);
    checkOutput("t5_ab_busy", 64'(busy), 64'd0);
    checkOutput("t5_ab_done", 64'(done), 64'd0);

    // Zero bursts completes immediately with pass
    applyStimulus(25'h0, 16'd0, 32'h7, 1'b0, 1'b0, '0);
    @(negedge clk);
    checkOutput("t5_n0_done", 64'(done), 64'd1);
    checkOutput("t5_n0_pass", 64'(pass), 64'd1);
    checkOutput("t5_n0_err",  64'(err_count), 64'd0);

`ifdef AVL_MEM_BIST_ERR_INJECT_EN
    // Single injected bit error during the write phase
    applyStimulus(25'h200, 16'd2, 32'h9, 1'b0, 1'b0, '0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_beats >= 2) break;
    end
    @(posedge clk);
    #1 inject_err = 1'b1;
    @(posedge clk);
    #1 inject_err = 1'b0;
    waitDone("t6");
    checkOutput("t6_err",  64'(err_count), 64'd1);
    checkOutput("t6_pass", 64'(pass), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
